// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//   8 x 16-bit register file sitting at the write-back end of the
//   destination-register select path. Provides two combinational read ports
//   with write-through bypass, one synchronous write port, and a per-register
//   busy scoreboard that stalls decode on read-after-write hazards.
//
// Ports
//   clk                 rising-edge clock, sole clock domain
//   reset               synchronous, active-high reset
//   rd_addr1/rd_use1    read port 1 address / port actually consumed
//   rd_data1            read port 1 data (combinational)
//   rd_addr2/rd_use2    read port 2 address / port actually consumed
//   rd_data2            read port 2 data (combinational)
//   wr_en/wr_addr/wr_data  write-back strobe, destination, value
//   issue_en/issue_dst  instruction with a destination leaves decode
//   busy_vec            bit i set: a write to Ri is still pending
//   stall               hold decode/fetch this cycle
// ---------------------------------------------------------------------------
module reg_file_wb #(
  parameter  int DATA_W   = 16,
  parameter  int ADDR_W   = 3,
  parameter  int LINK_REG = 7,
  localparam int NREGS    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_use1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_use2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic [NREGS-1:0]  busy_vec,
  output logic              stall
);

  // The link register is ordinary storage; only its range is sanity-checked.
  if (LINK_REG <= 0 || LINK_REG >= NREGS) begin : g_bad_link
    $error("reg_file_wb: LINK_REG out of range");
  end

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic                         haz1_s, haz2_s;
  logic                         wr_hit1_s, wr_hit2_s;

  // Same-cycle write to the address being read: bypass and hazard resolution.
  always_comb begin
    wr_hit1_s = wr_en && (wr_addr == rd_addr1);
    wr_hit2_s = wr_en && (wr_addr == rd_addr2);
  end

  // Read port 1: R0 hard zero, then write-through bypass, then storage.
  always_comb begin
    if (rd_addr1 == {ADDR_W{1'b0}}) begin
      rd_data1 = {DATA_W{1'b0}};
    end else if (wr_hit1_s) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_q[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if (rd_addr2 == {ADDR_W{1'b0}}) begin
      rd_data2 = {DATA_W{1'b0}};
    end else if (wr_hit2_s) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs_q[rd_addr2];
    end
  end

  // Hazard detection; busy_q[0] is always 0 so address 0 never stalls.
  always_comb begin
    haz1_s = rd_use1 && busy_q[rd_addr1] && !wr_hit1_s;
    haz2_s = rd_use2 && busy_q[rd_addr2] && !wr_hit2_s;
    stall  = haz1_s | haz2_s;
  end

  // Next register contents: full-width write, R0 forced to zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != {ADDR_W{1'b0}})) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = {DATA_W{1'b0}};
  end

  // Next scoreboard: a new issue outranks a completing write to the same reg,
  // because the issuing instruction is the newer producer.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (issue_en && !stall && (issue_dst == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wb
//   Directed scenarios followed by randomized traffic. Expected values come
//   from a behavioural model (register array + busy array) updated with the
//   architectural rules at each clock edge.
// ---------------------------------------------------------------------------
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, issue_dst;
  logic        rd_use1, rd_use2, wr_en, issue_en;
  logic [15:0] rd_data1, rd_data2, wr_data;
  logic [7:0]  busy_vec;
  logic        stall;

  int passed = 0;
  int total  = 0;

  logic [15:0] m_regs [8];
  logic        m_busy [8];

  reg_file_wb dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_use1(rd_use1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_use2(rd_use2), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dst(issue_dst),
    .busy_vec(busy_vec), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic m_stall();
    logic h1, h2;
    h1 = rd_use1 && m_busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
    h2 = rd_use2 && m_busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
    return h1 || h2;
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Apply inputs mid-cycle and compare combinational outputs with the model.
  task automatic drive(input logic rst,
                       input logic [2:0] a1, input logic u1,
                       input logic [2:0] a2, input logic u2,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ie, input logic [2:0] id);
    @(negedge clk);
    reset = rst; rd_addr1 = a1; rd_use1 = u1; rd_addr2 = a2; rd_use2 = u2;
    wr_en = we; wr_addr = wa; wr_data = wd; issue_en = ie; issue_dst = id;
    #1;
    check("rd_data1", rd_data1, m_read(rd_addr1));
    check("rd_data2", rd_data2, m_read(rd_addr2));
    check("busy_vec", {8'h00, busy_vec}, {8'h00, m_busy_vec()});
    check("stall",    {15'h0, stall},    {15'h0, m_stall()});
  endtask

  // Advance the model across the clock edge, then let the edge happen.
  task automatic tick();
    logic st;
    st = m_stall();
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 16'h0000; m_busy[i] = 1'b0; end
    end else begin
      if (wr_en && wr_addr != 3'd0) begin
        m_busy[wr_addr] = 1'b0;
        m_regs[wr_addr] = wr_data;
      end
      if (issue_en && !st && issue_dst != 3'd0) m_busy[issue_dst] = 1'b1;
    end
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_regs[i] = 16'hxxxx; m_busy[i] = 1'bx; end
    reset = 1'b1; rd_addr1 = 3'd0; rd_addr2 = 3'd0; rd_use1 = 1'b0; rd_use2 = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; issue_en = 1'b0; issue_dst = 3'd0;

    // 1: reset, then every address reads zero with nothing busy
    @(negedge clk);
    tick();
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'(a), 1'b1, 3'(7 - a), 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      check("reset_rd1", rd_data1, 16'h0000);
      check("reset_stall", {15'h0, stall}, 16'h0000);
      tick();
    end
    check("reset_busy", {8'h00, busy_vec}, 16'h0000);

    // 2: write R3 with same-cycle bypass on port 2, then stored read on port 1
    drive(1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    check("bypass_r3", rd_data2, 16'hBEEF);
    tick();
    drive(1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("stored_r3", rd_data1, 16'hBEEF);
    tick();

    // 3: R0 write and issue are dropped
    drive(1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
    check("r0_bypass", rd_data1, 16'h0000);
    tick();
    drive(1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("r0_read", rd_data1, 16'h0000);
    check("r0_busy", {8'h00, busy_vec}, 16'h0000);
    tick();

    // 4: link register hazard, blocked issue, resolution by write
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    check("link_busy", {8'h00, busy_vec}, 16'h0080);
    check("link_stall", {15'h0, stall}, 16'h0001);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b1, 3'd7, 16'h0042, 1'b0, 3'd0);
    check("link_busy5", {8'h00, busy_vec}, 16'h0080);
    check("link_resolve", {15'h0, stall}, 16'h0000);
    check("link_bypass", rd_data2, 16'h0042);
    tick();
    drive(1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("link_clear", {8'h00, busy_vec}, 16'h0000);
    tick();

    // 5: issue and write to R4 on the same edge keeps R4 busy
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4);
    tick();
    drive(1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("r4_busy", {8'h00, busy_vec}, 16'h0010);
    check("r4_stall", {15'h0, stall}, 16'h0001);
    tick();
    drive(1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("r4_data", rd_data1, 16'h1111);
    tick();
    drive(1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 16'h2222, 1'b0, 3'd0);
    check("r4_resolve", {15'h0, stall}, 16'h0000);
    tick();

    // 6: reset discards busy bits, data and a same-cycle write
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 16'h0005, 1'b1, 3'd2);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
    tick();
    drive(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 16'hFFFF, 1'b1, 3'd6);
    check("pre_rst_busy", {8'h00, busy_vec}, 16'h000C);
    tick();
    drive(1'b0, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    check("rst_busy", {8'h00, busy_vec}, 16'h0000);
    check("rst_r2", rd_data1, 16'h0000);
    check("rst_stall", {15'h0, stall}, 16'h0000);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0),
            3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            ($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
            ($urandom_range(0, 2) != 0), 3'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
